butterfly_addr_seq: RTL and testbench

Stage address sequencer for the iterative radix-2 transform. Sits directly downstream of the per-stage parameter page, which supplies stride, calcs-per-group and group offset for each stage. The sequencer accepts one stage descriptor at a time and walks it, emitting one butterfly operand-address pair plus twiddle index per cycle to the butterfly datapath over a valid/ready handshake. It signals completion of each stage and flags malformed descriptors.

---
 rtl/ntt_pkg.sv | 20 ++
 rtl/butterfly_addr_seq_if.sv | 38 +++
 rtl/pow2_log2.sv | 18 +
 rtl/butterfly_addr_seq.sv | 195 +++++++++++++++++++
 tb/tb_butterfly_addr_seq.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// Shared types and constants for the radix-2 transform address path.
package ntt_pkg;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned TW_W    = 9;
  localparam int unsigned CFG_W   = 3;
  localparam int unsigned MAX_CFG = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Transform size from point configuration: N = 16 << cfg.
  function automatic logic [ADDR_W:0] n_from_cfg(input logic [CFG_W-1:0] cfg);
    return (ADDR_W + 1)'(16) << cfg;
  endfunction

endpackage

// File: rtl/butterfly_addr_seq_if.sv
// Stage-descriptor and operand-pair handshake bundle of the address sequencer.
interface butterfly_addr_seq_if #(
  parameter int unsigned ADDR_W = ntt_pkg::ADDR_W,
  parameter int unsigned TW_W   = ntt_pkg::TW_W
);

  logic [2:0]        i_point_configuration;
  logic              i_stage_valid;
  logic              o_stage_ready;
  logic [ADDR_W-1:0] i_stride;
  logic [ADDR_W-1:0] i_calcs_per_group;
  logic [ADDR_W:0]   i_group_offset;
  logic              o_valid;
  logic              i_ready;
  logic [ADDR_W-1:0] o_addr_a;
  logic [ADDR_W-1:0] o_addr_b;
  logic [TW_W-1:0]   o_twiddle;
  logic              o_last;
  logic              o_stage_done;
  logic              o_error;

  // Sequencer side
  modport slave (
    input  i_point_configuration, i_stage_valid, i_stride, i_calcs_per_group,
    input  i_group_offset, i_ready,
    output o_stage_ready, o_valid, o_addr_a, o_addr_b, o_twiddle, o_last,
    output o_stage_done, o_error
  );

  // Parameter page / datapath side
  modport master (
    output i_point_configuration, i_stage_valid, i_stride, i_calcs_per_group,
    output i_group_offset, i_ready,
    input  o_stage_ready, o_valid, o_addr_a, o_addr_b, o_twiddle, o_last,
    input  o_stage_done, o_error
  );

endinterface

// File: rtl/pow2_log2.sv
// Priority encoder: index of the highest set bit (log2 of a power of two).
module pow2_log2 #(
  parameter int unsigned IN_W  = 11,
  parameter int unsigned OUT_W = 4
) (
  input  logic [IN_W-1:0]  value,
  output logic [OUT_W-1:0] log2_c
);

  // Highest set bit wins; zero input yields zero.
  always_comb begin
    log2_c = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (value[i]) log2_c = OUT_W'(i);
    end
  end

endmodule

// File: rtl/butterfly_addr_seq.sv
// Walks one radix-2 stage descriptor, emitting one operand-address pair and
// twiddle index per accepted handshake; flags malformed descriptors.
module butterfly_addr_seq #(
  parameter int unsigned ADDR_W = ntt_pkg::ADDR_W,
  parameter int unsigned TW_W   = ntt_pkg::TW_W
) (
  input logic                 clock,
  input logic                 i_reset,
  butterfly_addr_seq_if.slave bus
);

  import ntt_pkg::*;

  localparam int unsigned SUM_W = ADDR_W + 2;
  localparam int unsigned LOG_W = $clog2(ADDR_W + 2);

  state_t state, state_n;

  logic [ADDR_W:0]   base, base_n;
  logic [ADDR_W-1:0] j, j_n;
  logic [ADDR_W:0]   tw, tw_n;
  logic [ADDR_W-1:0] stride, stride_n;
  logic [ADDR_W-1:0] calcs, calcs_n;
  logic [ADDR_W:0]   offset, offset_n;
  logic [ADDR_W:0]   n_pts, n_pts_n;
  logic [ADDR_W:0]   step, step_n;

  logic              valid, valid_n;
  logic [ADDR_W-1:0] addr_a, addr_a_n;
  logic [ADDR_W-1:0] addr_b, addr_b_n;
  logic [TW_W-1:0]   twiddle, twiddle_n;
  logic              last, last_n;
  logic              stage_done, stage_done_n;
  logic              error, error_n;
  logic              stage_ready, stage_ready_n;

  logic [ADDR_W:0]   n_in_c;
  logic [LOG_W-1:0]  log2_c;
  logic              bad_c;
  logic              accept_c;
  logic              fire_c;
  logic [SUM_W-1:0]  sum_a_c, sum_b_c, span_c;

  // Twiddle step shift amount from the group offset.
  pow2_log2 #(
    .IN_W  (ADDR_W + 1),
    .OUT_W (LOG_W)
  ) u_log2 (
    .value  (bus.i_group_offset),
    .log2_c (log2_c)
  );

  assign n_in_c   = (ADDR_W + 1)'(n_from_cfg(bus.i_point_configuration));
  assign accept_c = stage_ready && bus.i_stage_valid;
  assign fire_c   = valid && bus.i_ready;

  // Descriptor sanity check, evaluated on the offered inputs.
  assign bad_c = (bus.i_stride == '0) ||
                 (bus.i_calcs_per_group == '0) ||
                 (bus.i_group_offset == '0) ||
                 (bus.i_group_offset > n_in_c) ||
                 ((SUM_W'(bus.i_stride) + SUM_W'(bus.i_calcs_per_group)) >
                  SUM_W'(bus.i_group_offset)) ||
                 (bus.i_point_configuration > CFG_W'(MAX_CFG));

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_n       = state;
    base_n        = base;
    j_n           = j;
    tw_n          = tw;
    stride_n      = stride;
    calcs_n       = calcs;
    offset_n      = offset;
    n_pts_n       = n_pts;
    step_n        = step;
    valid_n       = valid;
    addr_a_n      = addr_a;
    addr_b_n      = addr_b;
    twiddle_n     = twiddle;
    last_n        = 1'b0;
    stage_done_n  = 1'b0;
    error_n       = 1'b0;
    stage_ready_n = stage_ready;
    sum_a_c       = '0;
    sum_b_c       = '0;
    span_c        = '0;

    unique case (state)
      IDLE, DONE: begin
        stage_ready_n = 1'b1;
        if (accept_c) begin
          stride_n = bus.i_stride;
          calcs_n  = bus.i_calcs_per_group;
          offset_n = bus.i_group_offset;
          n_pts_n  = n_in_c;
          step_n   = n_in_c >> log2_c;
          base_n   = '0;
          j_n      = '0;
          tw_n     = '0;
          if (bad_c) begin
            state_n = DONE;
            error_n = 1'b1;
          end else begin
            state_n       = RUN;
            valid_n       = 1'b1;
            stage_ready_n = 1'b0;
          end
        end else if (state == DONE) begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (fire_c) begin
          if (last) begin
            state_n       = DONE;
            valid_n       = 1'b0;
            stage_done_n  = 1'b1;
            stage_ready_n = 1'b1;
          end else if (j == calcs - ADDR_W'(1)) begin
            j_n    = '0;
            tw_n   = '0;
            base_n = base + offset;
          end else begin
            j_n  = j + ADDR_W'(1);
            tw_n = tw + step;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Pair outputs follow the counters they will be registered alongside.
    if (valid_n) begin
      sum_a_c   = SUM_W'(base_n) + SUM_W'(j_n);
      sum_b_c   = sum_a_c + SUM_W'(stride_n);
      span_c    = SUM_W'(base_n) + SUM_W'(offset_n);
      addr_a_n  = ADDR_W'(sum_a_c);
      addr_b_n  = ADDR_W'(sum_b_c);
      twiddle_n = TW_W'(tw_n);
      last_n    = (j_n == calcs_n - ADDR_W'(1)) && (span_c >= SUM_W'(n_pts_n));
    end
  end

  // State, counter and output registers; reset wins over everything.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state       <= IDLE;
      base        <= '0;
      j           <= '0;
      tw          <= '0;
      stride      <= '0;
      calcs       <= '0;
      offset      <= '0;
      n_pts       <= '0;
      step        <= '0;
      valid       <= 1'b0;
      addr_a      <= '0;
      addr_b      <= '0;
      twiddle     <= '0;
      last        <= 1'b0;
      stage_done  <= 1'b0;
      error       <= 1'b0;
      stage_ready <= 1'b0;
    end else begin
      state       <= state_n;
      base        <= base_n;
      j           <= j_n;
      tw          <= tw_n;
      stride      <= stride_n;
      calcs       <= calcs_n;
      offset      <= offset_n;
      n_pts       <= n_pts_n;
      step        <= step_n;
      valid       <= valid_n;
      addr_a      <= addr_a_n;
      addr_b      <= addr_b_n;
      twiddle     <= twiddle_n;
      last        <= last_n;
      stage_done  <= stage_done_n;
      error       <= error_n;
      stage_ready <= stage_ready_n;
    end
  end

  assign bus.o_stage_ready = stage_ready;
  assign bus.o_valid       = valid;
  assign bus.o_addr_a      = addr_a;
  assign bus.o_addr_b      = addr_b;
  assign bus.o_twiddle     = twiddle;
  assign bus.o_last        = last;
  assign bus.o_stage_done  = stage_done;
  assign bus.o_error       = error;

endmodule

// File: tb/tb_butterfly_addr_seq.sv
// Directed bench for the butterfly stage address sequencer.
module tb_butterfly_addr_seq;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned TW_W   = 9;

  logic clock = 1'b0;
  logic i_reset;

  int n_checks = 0;
  int n_pass   = 0;

  int exp_a[$];
  int exp_b[$];
  int exp_t[$];

  // Hand-computed sequence for cfg=0, stride=4, calcs=4, offset=8.
  int t2_a[8] = '{0, 1, 2, 3, 8, 9, 10, 11};
  int t2_b[8] = '{4, 5, 6, 7, 12, 13, 14, 15};
  int t2_t[8] = '{0, 2, 4, 6, 0, 2, 4, 6};

  butterfly_addr_seq_if #(.ADDR_W(ADDR_W), .TW_W(TW_W)) bus ();

  butterfly_addr_seq #(.ADDR_W(ADDR_W), .TW_W(TW_W)) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Butterflies 2k/2k+1, twiddle 0 (cfg=0, stride=1, calcs=1, offset=2).
  task automatic load_t1();
    exp_a.delete(); exp_b.delete(); exp_t.delete();
    for (int k = 0; k < 8; k++) begin
      exp_a.push_back(2 * k);
      exp_b.push_back(2 * k + 1);
      exp_t.push_back(0);
    end
  endtask

  task automatic load_t2();
    exp_a.delete(); exp_b.delete(); exp_t.delete();
    for (int k = 0; k < 8; k++) begin
      exp_a.push_back(t2_a[k]);
      exp_b.push_back(t2_b[k]);
      exp_t.push_back(t2_t[k]);
    end
  endtask

  // Reference walk: groups of calcs butterflies, twiddle = j * (N / offset).
  task automatic load_model(input int cfg, input int stride, input int calcs, input int offset);
    int n;
    int tstep;
    n     = 16 << cfg;
    tstep = n / offset;
    exp_a.delete(); exp_b.delete(); exp_t.delete();
    for (int base = 0; base < n; base += offset) begin
      for (int jj = 0; jj < calcs; jj++) begin
        exp_a.push_back(base + jj);
        exp_b.push_back(base + jj + stride);
        exp_t.push_back(jj * tstep);
      end
    end
  endtask

  // Present a descriptor for one cycle, then scramble the descriptor fields.
  task automatic offer(input int cfg, input int stride, input int calcs, input int offset);
    check("accept_ready", int'(bus.o_stage_ready), 1);
    bus.i_point_configuration = 3'(cfg);
    bus.i_stride              = ADDR_W'(stride);
    bus.i_calcs_per_group     = ADDR_W'(calcs);
    bus.i_group_offset        = (ADDR_W + 1)'(offset);
    bus.i_stage_valid         = 1'b1;
    step();
    bus.i_stage_valid         = 1'b0;
    bus.i_point_configuration = 3'd7;
    bus.i_stride              = ADDR_W'(3);
    bus.i_calcs_per_group     = ADDR_W'(7);
    bus.i_group_offset        = (ADDR_W + 1)'(5);
  endtask

  task automatic check_pair(input string name, input int i, input bit is_last);
    check($sformatf("%s[%0d].valid", name, i), int'(bus.o_valid), 1);
    check($sformatf("%s[%0d].a", name, i), int'(bus.o_addr_a), exp_a[i]);
    check($sformatf("%s[%0d].b", name, i), int'(bus.o_addr_b), exp_b[i]);
    check($sformatf("%s[%0d].tw", name, i), int'(bus.o_twiddle), exp_t[i]);
    check($sformatf("%s[%0d].last", name, i), int'(bus.o_last), int'(is_last));
    check($sformatf("%s[%0d].done", name, i), int'(bus.o_stage_done), 0);
  endtask

  // Consume the expected pairs, holding i_ready low 3 cycles on stall0/stall1.
  task automatic run_pairs(input string name, input int stall0, input int stall1);
    int cnt;
    cnt = exp_a.size();
    for (int i = 0; i < cnt; i++) begin
      check_pair(name, i, i == cnt - 1);
      if (i == stall0 || i == stall1) begin
        bus.i_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step();
          check_pair(name, i, i == cnt - 1);
        end
        bus.i_ready = 1'b1;
      end
      step();
    end
    check($sformatf("%s.done_pulse", name), int'(bus.o_stage_done), 1);
    check($sformatf("%s.valid_off", name), int'(bus.o_valid), 0);
    check($sformatf("%s.last_off", name), int'(bus.o_last), 0);
    check($sformatf("%s.ready_done", name), int'(bus.o_stage_ready), 1);
  endtask

  task automatic bad_desc(input string name, input int cfg, input int stride,
                          input int calcs, input int offset);
    offer(cfg, stride, calcs, offset);
    check($sformatf("%s.valid", name), int'(bus.o_valid), 0);
    check($sformatf("%s.error", name), int'(bus.o_error), 1);
    check($sformatf("%s.ready", name), int'(bus.o_stage_ready), 1);
    check($sformatf("%s.done", name), int'(bus.o_stage_done), 0);
    step();
    check($sformatf("%s.error_off", name), int'(bus.o_error), 0);
    check($sformatf("%s.valid_off", name), int'(bus.o_valid), 0);
    check($sformatf("%s.ready_idle", name), int'(bus.o_stage_ready), 1);
  endtask

  initial begin
    i_reset                   = 1'b1;
    bus.i_stage_valid         = 1'b0;
    bus.i_ready               = 1'b1;
    bus.i_point_configuration = 3'd0;
    bus.i_stride              = '0;
    bus.i_calcs_per_group     = '0;
    bus.i_group_offset        = '0;
    step();
    step();

    // Reset state
    check("rst.valid", int'(bus.o_valid), 0);
    check("rst.last", int'(bus.o_last), 0);
    check("rst.done", int'(bus.o_stage_done), 0);
    check("rst.error", int'(bus.o_error), 0);
    check("rst.ready", int'(bus.o_stage_ready), 0);
    check("rst.a", int'(bus.o_addr_a), 0);
    check("rst.b", int'(bus.o_addr_b), 0);
    check("rst.tw", int'(bus.o_twiddle), 0);
    i_reset = 1'b0;
    step();
    check("idle.ready", int'(bus.o_stage_ready), 1);
    check("idle.valid", int'(bus.o_valid), 0);

    // Canonical first stage: 8 adjacent pairs
    load_t1();
    offer(0, 1, 1, 2);
    run_pairs("t1", -1, -1);
    step();
    check("t1.done_one_cycle", int'(bus.o_stage_done), 0);
    check("t1.idle_ready", int'(bus.o_stage_ready), 1);

    // Two groups of four, twiddle step 2
    load_t2();
    offer(0, 4, 4, 8);
    run_pairs("t2", -1, -1);

    // Same descriptor offered back-to-back in DONE, with stalls on pairs 2 and 5
    load_t2();
    offer(0, 4, 4, 8);
    run_pairs("t3", 2, 5);
    step();

    // Largest transform, final stage: 512 pairs, twiddle step 1
    load_model(6, 512, 512, 1024);
    offer(6, 512, 512, 1024);
    run_pairs("t4", -1, -1);
    check("t4.last_a", exp_a[511], 511);
    step();

    // Malformed descriptors
    bad_desc("e_stride0", 0, 0, 4, 8);
    bad_desc("e_cfg7", 7, 1, 1, 2);
    bad_desc("e_off_gt_n", 0, 1, 1, 32);
    bad_desc("e_span", 0, 4, 5, 8);
    bad_desc("e_calcs0", 0, 1, 0, 2);
    bad_desc("e_off0", 0, 1, 1, 0);

    // Valid descriptor accepted normally after errors
    load_t1();
    offer(0, 1, 1, 2);
    run_pairs("t5", -1, -1);
    step();

    // Reset at pair 3 drops the stage without a done pulse
    load_t1();
    offer(0, 1, 1, 2);
    for (int i = 0; i < 3; i++) begin
      check_pair("t6", i, 1'b0);
      step();
    end
    check_pair("t6", 3, 1'b0);
    i_reset = 1'b1;
    step();
    check("t6.rst_valid", int'(bus.o_valid), 0);
    check("t6.rst_done", int'(bus.o_stage_done), 0);
    check("t6.rst_ready", int'(bus.o_stage_ready), 0);
    check("t6.rst_a", int'(bus.o_addr_a), 0);
    i_reset = 1'b0;
    step();
    check("t6.post_valid", int'(bus.o_valid), 0);
    check("t6.post_done", int'(bus.o_stage_done), 0);
    check("t6.post_ready", int'(bus.o_stage_ready), 1);

    // Fresh stage restarts at (0,1)
    load_t1();
    offer(0, 1, 1, 2);
    run_pairs("t7", -1, -1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
